sd_fifo_head_s: RTL and testbench

Write-side (producer-facing) control stage of the "S" FIFO. It accepts words from an upstream srdy/drdy source, generates memory write enables and addresses, and publishes its write pointer to the paired read-side tail stage. It consumes that stage's read pointer to compute full and usage. It sits between the upstream pipeline and the FIFO storage, and can operate as the write half of a two-clock FIFO.

---
 rtl/sdlib_fifo_pkg.sv | 29 ++
 rtl/sd_fifo_head_s_sync2.sv | 35 +++
 rtl/sd_fifo_head_s.sv | 142 ++++++++++++++
 tb/tb_sd_fifo_head_s.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdlib_fifo_pkg.sv
// sdlib_fifo_pkg
//   Shared definitions for the "S" FIFO head/tail control stages.
//   Holds the binary <-> Gray pointer conversions used on both sides of a
//   clock-domain crossing, so head and tail always agree on the encoding.
//
//   The conversions operate on a 32-bit word. Callers pass a narrower pointer
//   zero-extended and take back the low bits they need; zero upper bits leave
//   the low-order result identical to a native-width conversion.
package sdlib_fifo_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2grey(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB downward, done in log2 doubling steps.
  function automatic ptr_word_t grey2bin(input ptr_word_t g);
    ptr_word_t b;
    b = g;
    for (int unsigned s = 1; s < PTR_MAX_W; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/sd_fifo_head_s_sync2.sv
// sd_sync2
//   Two-flop synchronizer of parameterizable width with asynchronous,
//   active-high reset. Used to bring a Gray-coded pointer into the local
//   clock domain; only one bit may change per source update.
//
//   Ports:
//     clk    in   destination-domain clock
//     reset  in   asynchronous, active-high reset (flops clear to 0)
//     d_i    in   [width-1:0] value from the foreign domain
//     q_o    out  [width-1:0] synchronized value, two clk edges later
module sd_sync2 #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [width-1:0] meta_q;
  logic [width-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sd_fifo_head_s.sv
// sd_fifo_head_s
//   Write-side control stage of the "S" FIFO. Accepts words from an upstream
//   srdy/drdy source, produces memory write strobe/address, publishes the
//   write pointer to the paired tail stage and consumes the tail's read
//   pointer to derive full and usage.
//
//   Parameters:
//     depth        FIFO size in words (power of 2, >= 2)
//     async        1: pointers exchanged as Gray code across clock domains
//                  0: binary pointers, same clock
//     afull_level  usage threshold for c_afull (1..depth)
//     asz          address width, derived from depth
//
//   Ports:
//     clk         in   write-domain clock
//     reset       in   asynchronous, active-high reset
//     c_srdy      in   upstream word valid
//     c_drdy      out  block can accept a word
//     wr_en       out  memory write strobe
//     wr_addr     out  [asz-1:0] memory write address
//     wrptr_head  out  [asz:0] write pointer to tail (binary or Gray)
//     rdptr_tail  in   [asz:0] read pointer from tail (binary or Gray)
//     c_usage     out  [asz:0] words held, as seen from the write side
//     c_afull     out  almost-full flag
//
//   Build option: define SDLIB_FIFO_HEAD_AFULL_EN to enable the registered
//   almost-full flag; otherwise c_afull is tied low.
module sd_fifo_head_s
  import sdlib_fifo_pkg::*;
#(
  parameter  int depth       = 16,
  parameter  int async       = 0,
  parameter  int afull_level = depth - 2,
  localparam int asz         = $clog2(depth)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           c_srdy,
  output logic           c_drdy,
  output logic           wr_en,
  output logic [asz-1:0] wr_addr,
  output logic [asz:0]   wrptr_head,
  input  logic [asz:0]   rdptr_tail,
  output logic [asz:0]   c_usage,
  output logic           c_afull
);

  logic [asz:0] wrptr;
  logic [asz:0] nxt_wrptr;
  logic [asz:0] rdptr;
  logic         full;

  // Words held between two pointers; the wrap bits select which half of the
  // doubled address space the write pointer is in.
  function automatic logic [asz:0] usage_of(input logic [asz:0] w,
                                            input logic [asz:0] r);
    if (w[asz] == r[asz]) begin
      return w - r;
    end else begin
      return ({1'b0, w[asz-1:0]} + (asz+1)'(depth)) - {1'b0, r[asz-1:0]};
    end
  endfunction

  assign full      = (wrptr[asz-1:0] == rdptr[asz-1:0]) && (wrptr[asz] != rdptr[asz]);
  assign c_drdy    = !full && !reset;
  assign wr_en     = c_srdy && c_drdy;
  assign wr_addr   = wrptr[asz-1:0];
  assign nxt_wrptr = wr_en ? wrptr + (asz+1)'(1) : wrptr;
  assign c_usage   = reset ? '0 : usage_of(wrptr, rdptr);

  generate
    if (async != 0) begin : g_async
      logic [asz:0] rdptr_sync;
      logic [asz:0] wrptr_head_q;
      logic [asz:0] wrptr_head_d;

      sd_sync2 #(
        .width (asz + 1)
      ) u_rdptr_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rdptr_tail),
        .q_o   (rdptr_sync)
      );

      assign rdptr        = (asz+1)'(grey2bin(ptr_word_t'(rdptr_sync)));
      assign wrptr_head_d = (asz+1)'(bin2grey(ptr_word_t'(nxt_wrptr)));

      // Only the Gray register is stored; the binary pointer is decoded from
      // it so the published and local pointers can never disagree.
      assign wrptr        = (asz+1)'(grey2bin(ptr_word_t'(wrptr_head_q)));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wrptr_head_q <= '0;
        end else begin
          wrptr_head_q <= wrptr_head_d;
        end
      end

      assign wrptr_head = wrptr_head_q;
    end else begin : g_sync
      logic [asz:0] wrptr_q;
      logic [asz:0] wrptr_d;

      assign wrptr_d = nxt_wrptr;
      assign rdptr   = rdptr_tail;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wrptr_q <= '0;
        end else begin
          wrptr_q <= wrptr_d;
        end
      end

      assign wrptr      = wrptr_q;
      assign wrptr_head = wrptr_q;
    end
  endgenerate

`ifdef SDLIB_FIFO_HEAD_AFULL_EN
  logic c_afull_q;
  logic c_afull_d;

  // Looks ahead to the post-write usage so the flag lands on the write edge.
  assign c_afull_d = usage_of(nxt_wrptr, rdptr) >= (asz+1)'(afull_level);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_afull_q <= 1'b0;
    end else begin
      c_afull_q <= c_afull_d;
    end
  end

  assign c_afull = c_afull_q;
`else
  assign c_afull = 1'b0;
`endif

endmodule

// File: tb/tb_sd_fifo_head_s.sv
// tb_sd_fifo_head_s
//   Bench for sd_fifo_head_s: one same-clock instance (depth 4) and one
//   two-clock instance (depth 8, Gray pointers). The bench plays the tail
//   stage and the storage, tracking words as plain totals written and read.
module tb_sd_fifo_head_s;

  localparam int SD     = 4;
  localparam int AD     = 8;
  localparam int S_LVL  = 3;
  localparam int NWORDS = 2000;

  logic clk;
  logic rclk;
  logic reset;

  logic       c_srdy_s, c_drdy_s, wr_en_s, c_afull_s;
  logic [1:0] wr_addr_s;
  logic [2:0] wrptr_head_s, rdptr_tail_s, c_usage_s;

  logic       c_srdy_a, c_drdy_a, wr_en_a, c_afull_a;
  logic [2:0] wr_addr_a;
  logic [3:0] wrptr_head_a, rdptr_tail_a, c_usage_a;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int   wcnt_s, rcnt_s, wcnt_a, rcnt_a;
  logic afull_exp_s;
  bit   a_rd_en = 1'b0;
  logic [3:0] prev_head_a;

  logic [31:0] mem_s [SD];
  logic [31:0] mem_a [AD];
  logic [31:0] q_s [$];
  logic [31:0] q_a [$];

  sd_fifo_head_s #(
    .depth       (SD),
    .async       (0),
    .afull_level (S_LVL)
  ) u_dut_sync (
    .clk        (clk),
    .reset      (reset),
    .c_srdy     (c_srdy_s),
    .c_drdy     (c_drdy_s),
    .wr_en      (wr_en_s),
    .wr_addr    (wr_addr_s),
    .wrptr_head (wrptr_head_s),
    .rdptr_tail (rdptr_tail_s),
    .c_usage    (c_usage_s),
    .c_afull    (c_afull_s)
  );

  sd_fifo_head_s #(
    .depth       (AD),
    .async       (1),
    .afull_level (6)
  ) u_dut_async (
    .clk        (clk),
    .reset      (reset),
    .c_srdy     (c_srdy_a),
    .c_drdy     (c_drdy_a),
    .wr_en      (wr_en_a),
    .wr_addr    (wr_addr_a),
    .wrptr_head (wrptr_head_a),
    .rdptr_tail (rdptr_tail_a),
    .c_usage    (c_usage_a),
    .c_afull    (c_afull_a)
  );

  // Write clock period 100 units, read clock period 270 units (~100/37 ratio).
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  initial begin
    rclk = 1'b0;
    #3;
    forever begin
      rclk = 1'b1;
      #135;
      rclk = 1'b0;
      #135;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int gray(input int n);
    return n ^ (n >> 1);
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    c_srdy_s     = 1'b1;
    c_srdy_a     = 1'b1;
    wcnt_s       = 0;
    rcnt_s       = 0;
    wcnt_a       = 0;
    rcnt_a       = 0;
    afull_exp_s  = 1'b0;
    q_s.delete();
    q_a.delete();
    rdptr_tail_s = '0;
    rdptr_tail_a = '0;
    prev_head_a  = '0;
    #10;
    check_eq("rst_s_drdy",  32'(c_drdy_s), 0);
    check_eq("rst_s_wren",  32'(wr_en_s), 0);
    check_eq("rst_s_usage", 32'(c_usage_s), 0);
    check_eq("rst_s_head",  32'(wrptr_head_s), 0);
    check_eq("rst_s_afull", 32'(c_afull_s), 0);
    check_eq("rst_a_drdy",  32'(c_drdy_a), 0);
    check_eq("rst_a_wren",  32'(wr_en_a), 0);
    check_eq("rst_a_usage", 32'(c_usage_a), 0);
    check_eq("rst_a_head",  32'(wrptr_head_a), 0);
    @(negedge clk);
    c_srdy_s = 1'b0;
    c_srdy_a = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #10;
    check_eq("post_rst_s_drdy",  32'(c_drdy_s), 1);
    check_eq("post_rst_s_head",  32'(wrptr_head_s), 0);
    check_eq("post_rst_s_usage", 32'(c_usage_s), 0);
    check_eq("post_rst_a_drdy",  32'(c_drdy_a), 1);
    check_eq("post_rst_a_head",  32'(wrptr_head_a), 0);
    @(posedge clk);
    #10;
  endtask

  // One write-clock cycle on the same-clock instance; entered 10 units after
  // a rising edge. The optional read is the tail popping one word.
  task automatic sync_cycle(input bit srdy, input bit rd_req);
    int          occ;
    bit          exp_wr;
    logic        cap_wr;
    logic [1:0]  cap_addr;
    logic [31:0] d;
    c_srdy_s = srdy;
    if (rd_req && wcnt_s > rcnt_s) begin
      check_eq("s_data", mem_s[rcnt_s % SD], q_s.pop_front());
      rcnt_s++;
    end
    rdptr_tail_s = 3'(rcnt_s % (2 * SD));
    @(negedge clk);
    occ    = wcnt_s - rcnt_s;
    exp_wr = srdy && (occ != SD);
    check_eq("s_drdy",  32'(c_drdy_s), 32'(occ != SD));
    check_eq("s_wren",  32'(wr_en_s), 32'(exp_wr));
    check_eq("s_addr",  32'(wr_addr_s), 32'(wcnt_s % SD));
    check_eq("s_head",  32'(wrptr_head_s), 32'(wcnt_s % (2 * SD)));
    check_eq("s_usage", 32'(c_usage_s), 32'(occ));
`ifdef SDLIB_FIFO_HEAD_AFULL_EN
    check_eq("s_afull", 32'(c_afull_s), 32'(afull_exp_s));
`else
    check_eq("s_afull", 32'(c_afull_s), 0);
`endif
    cap_wr   = wr_en_s;
    cap_addr = wr_addr_s;
    d        = $urandom;
    @(posedge clk);
    if (cap_wr) mem_s[cap_addr] = d;
    if (exp_wr) begin
      q_s.push_back(d);
      wcnt_s++;
    end
    afull_exp_s = (wcnt_s - rcnt_s) >= S_LVL;
    #10;
  endtask

  // Tail side of the two-clock instance, running on the read clock.
  initial begin
    forever begin
      @(posedge rclk);
      #10;
      if (a_rd_en && wcnt_a > rcnt_a && ($urandom % 2 == 0)) begin
        check_eq("a_data", mem_a[rcnt_a % AD], q_a.pop_front());
        rcnt_a++;
        rdptr_tail_a = 4'(gray(rcnt_a % (2 * AD)));
      end
    end
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic        cap_wr;
    logic [2:0]  cap_addr;
    logic [31:0] d;

    c_srdy_s     = 1'b0;
    c_srdy_a     = 1'b0;
    rdptr_tail_s = '0;
    rdptr_tail_a = '0;
    do_reset();

    // Fill with tail idle: four writes, then held off.
    for (int i = 0; i < 6; i++) sync_cycle(1'b1, 1'b0);
    // One read at full frees exactly one slot; refills at address 0.
    sync_cycle(1'b1, 1'b1);
    sync_cycle(1'b1, 1'b0);
    // Interleaved reads and writes carry the pointer through its wrap.
    for (int i = 0; i < 16; i++) sync_cycle(i % 2 == 1, i % 2 == 0);
    for (int i = 0; i < 400; i++) sync_cycle(($urandom % 3) != 0, ($urandom % 2) == 0);

    // Reset in the middle of operation with three words held.
    do_reset();
    for (int i = 0; i < 3; i++) sync_cycle(1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) sync_cycle(($urandom % 2) == 0, ($urandom % 2) == 0);

    // Two-clock instance under random traffic.
    a_rd_en = 1'b1;
    cyc = 0;
    while (wcnt_a < NWORDS && cyc < 40000) begin
      c_srdy_a = ($urandom % 4) != 0;
      @(negedge clk);
      check_eq("a_addr",   32'(wr_addr_a), 32'(wcnt_a % AD));
      check_eq("a_head",   32'(wrptr_head_a), 32'(gray(wcnt_a % (2 * AD))));
      check_eq("a_head_1bit", 32'($countones(wrptr_head_a ^ prev_head_a) <= 1), 1);
      check_eq("a_usage_lo", 32'(int'(c_usage_a) >= (wcnt_a - rcnt_a)), 1);
      check_eq("a_usage_hi", 32'(c_usage_a <= 4'(AD)), 1);
      check_eq("a_no_ovf", 32'(wr_en_a && (wcnt_a - rcnt_a) >= AD), 0);
      check_eq("a_wr_srdy", 32'(wr_en_a && !c_srdy_a), 0);
`ifndef SDLIB_FIFO_HEAD_AFULL_EN
      check_eq("a_afull", 32'(c_afull_a), 0);
`endif
      prev_head_a = wrptr_head_a;
      cap_wr      = wr_en_a;
      cap_addr    = wr_addr_a;
      d           = $urandom;
      @(posedge clk);
      if (cap_wr) begin
        mem_a[cap_addr] = d;
        q_a.push_back(d);
        wcnt_a++;
      end
      #10;
      cyc++;
    end
    check_eq("a_words_done", 32'(wcnt_a >= NWORDS), 1);

    // Drain; once the tail pointer has crossed, usage must settle to zero.
    c_srdy_a = 1'b0;
    cyc = 0;
    while (rcnt_a != wcnt_a && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    check_eq("a_drained", 32'(rcnt_a == wcnt_a), 1);
    a_rd_en = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("a_final_usage", 32'(c_usage_a), 0);
    check_eq("a_final_drdy",  32'(c_drdy_a), 1);
    check_eq("a_final_head",  32'(wrptr_head_a), 32'(gray(wcnt_a % (2 * AD))));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
